// File: rtl/ovl_hold_value_mc.sv
// ovl_hold_value_mc: multi-channel checker that a slice, once it changes to its expected value, holds it for MIN..MAX cycles
module ovl_hold_value_mc #(
    parameter int    severity_level = 1,
    parameter int    NUM_CH         = 4,
    parameter int    WIDTH          = 2,
    parameter int    MIN            = 1,
    parameter int    MAX            = 0,
    parameter int    property_type  = 0,
    parameter int    coverage_level = 2,
    parameter int    COUNT_W        = 8,
    parameter string msg            = "VIOLATION"
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    enable,
    input  logic [NUM_CH*WIDTH-1:0] test_expr,
    input  logic [NUM_CH*WIDTH-1:0] value,
    output logic [2:0]              fire,
    output logic [NUM_CH-1:0]       fire_chan,
    output logic [COUNT_W-1:0]      err_count
);
    localparam int HI = (MIN > MAX) ? MIN : MAX;
    localparam int CW = $clog2(HI + 2);
    localparam logic [CW-1:0] MIN_C = CW'(MIN);
    localparam logic [CW-1:0] MAX_C = CW'(MAX);
    localparam bit ASSERT_ON = property_type != 2;
    localparam bit COVER_ON  = (coverage_level & 2) != 0;

    typedef enum logic {IDLE, HOLD} state_t;

    logic [NUM_CH-1:0]  viol_d, succ_d;
    logic               xz_d;
    logic [2:0]         fire_q;
    logic [NUM_CH-1:0]  fire_chan_q;
    logic [COUNT_W-1:0] err_q;

    if (MAX != 0 && MAX < MIN) begin : g_param_err
        $error("%s: MAX (%0d) < MIN (%0d), severity %0d", msg, MAX, MIN, severity_level);
    end

`ifdef SYNTHESIS
    assign xz_d = 1'b0;
`else
    assign xz_d = enable && $isunknown(test_expr);
`endif

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        logic [WIDTH-1:0] s, v, prev_q, prev_d, vlat_q, vlat_d;
        logic [CW-1:0]    cnt_q, cnt_d, inc;
        logic             pv_q, pv_d, xz, viol, succ;
        state_t           st_q, st_d;
        assign s = test_expr[i*WIDTH +: WIDTH];
        assign v = value[i*WIDTH +: WIDTH];
`ifdef SYNTHESIS
        assign xz = 1'b0;
`else
        assign xz = $isunknown(s);
`endif
        assign inc = (MAX == 0 && &cnt_q) ? cnt_q : cnt_q + 1'b1;
        assign viol_d[i] = viol;
        assign succ_d[i] = succ;
        // next-state for one channel; an X/Z slice leaves the channel untouched
        always_comb begin
            st_d = st_q;
            cnt_d = cnt_q;
            prev_d = prev_q;
            vlat_d = vlat_q;
            pv_d = pv_q;
            viol = 1'b0;
            succ = 1'b0;
            if (enable && !xz) begin
                prev_d = s;
                pv_d = 1'b1;
                if (st_q == IDLE) begin
                    if (pv_q && s != prev_q && s == v) begin
                        st_d = HOLD;
                        vlat_d = v;
                        cnt_d = CW'(1);
                    end
                end else if (s == vlat_q) begin
                    cnt_d = inc;
                    if (MAX != 0 && inc > MAX_C) begin
                        viol = 1'b1;
                        st_d = IDLE;
                        cnt_d = '0;
                    end
                end else begin
                    viol = (MIN != 0) && (cnt_q < MIN_C);
                    succ = !viol;
                    st_d = IDLE;
                    cnt_d = '0;
                end
            end
        end
        // per-channel state registers
        always_ff @(posedge clock or negedge reset) begin
            if (!reset) begin
                st_q <= IDLE;
                cnt_q <= '0;
                prev_q <= '0;
                vlat_q <= '0;
                pv_q <= 1'b0;
            end else begin
                st_q <= st_d;
                cnt_q <= cnt_d;
                prev_q <= prev_d;
                vlat_q <= vlat_d;
                pv_q <= pv_d;
            end
        end
    end

    // registered pulses and the saturating violation-cycle counter
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            fire_q <= '0;
            fire_chan_q <= '0;
            err_q <= '0;
        end else begin
            fire_chan_q <= ASSERT_ON ? viol_d : '0;
            fire_q <= {COVER_ON && |succ_d, xz_d, ASSERT_ON && |viol_d};
            if (ASSERT_ON && |viol_d && !(&err_q)) err_q <= err_q + 1'b1;
        end
    end

    assign fire = fire_q;
    assign fire_chan = fire_chan_q;
    assign err_count = err_q;
endmodule

// File: tb/tb_ovl_hold_value_mc.sv
// tb_ovl_hold_value_mc: directed checks of hold window, enable freeze, reset and saturation
module tb_ovl_hold_value_mc;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       en_a = 1'b1, en_b = 1'b1;
    logic [1:0] te_a = 2'b00, val_a = 2'b10;
    logic [7:0] te_b = 8'h00, val_b = 8'b10101010;
    logic [2:0] fire_a, fire_b;
    logic [0:0] fc_a;
    logic [3:0] fc_b;
    logic [1:0] ec_a;
    logic [7:0] ec_b;
    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    ovl_hold_value_mc #(.NUM_CH(1), .WIDTH(2), .MIN(3), .MAX(5), .COUNT_W(2)) u_a (
        .clock(clk), .reset(rst_n), .enable(en_a), .test_expr(te_a), .value(val_a),
        .fire(fire_a), .fire_chan(fc_a), .err_count(ec_a));

    ovl_hold_value_mc #(.NUM_CH(4), .WIDTH(2), .MIN(2), .MAX(0), .COUNT_W(8)) u_b (
        .clock(clk), .reset(rst_n), .enable(en_b), .test_expr(te_b), .value(val_b),
        .fire(fire_b), .fire_chan(fc_b), .err_count(ec_b));

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        repeat (2) tick();
        vectors++; if (fire_a !== 3'b000 || fc_a !== 1'b0 || ec_a !== 2'd0) begin miscompares++; $display("FAIL reset_a fire=%b chan=%b cnt=%0d want 000/0/0", fire_a, fc_a, ec_a); end
        vectors++; if (fire_b !== 3'b000 || fc_b !== 4'b0000 || ec_b !== 8'd0) begin miscompares++; $display("FAIL reset_b fire=%b chan=%b cnt=%0d want 000/0000/0", fire_b, fc_b, ec_b); end
        rst_n = 1'b1;
    endtask

    task automatic test_success;
        te_a = 2'b00; tick();
        te_a = 2'b10; tick();
        repeat (3) tick();
        vectors++; if (fire_a !== 3'b000) begin miscompares++; $display("FAIL succ_holding fire=%b want 000", fire_a); end
        te_a = 2'b01; tick();
        vectors++; if (fire_a !== 3'b100 || fc_a !== 1'b0) begin miscompares++; $display("FAIL succ_cover fire=%b chan=%b want 100/0", fire_a, fc_a); end
        tick();
        vectors++; if (fire_a !== 3'b000 || ec_a !== 2'd0) begin miscompares++; $display("FAIL succ_pulse fire=%b cnt=%0d want 000/0", fire_a, ec_a); end
    endtask

    task automatic test_too_short;
        te_a = 2'b10; tick();
        tick();
        te_a = 2'b00; tick();
        vectors++; if (fire_a !== 3'b001 || fc_a !== 1'b1 || ec_a !== 2'd1) begin miscompares++; $display("FAIL short_fire fire=%b chan=%b cnt=%0d want 001/1/1", fire_a, fc_a, ec_a); end
        tick();
        vectors++; if (fire_a !== 3'b000 || fc_a !== 1'b0 || ec_a !== 2'd1) begin miscompares++; $display("FAIL short_pulse fire=%b chan=%b cnt=%0d want 000/0/1", fire_a, fc_a, ec_a); end
    endtask

    task automatic test_too_long;
        te_a = 2'b10; tick();
        repeat (4) tick();
        vectors++; if (fire_a !== 3'b000) begin miscompares++; $display("FAIL long_at_max fire=%b want 000", fire_a); end
        tick();
        vectors++; if (fire_a !== 3'b001 || fc_a !== 1'b1 || ec_a !== 2'd2) begin miscompares++; $display("FAIL long_fire fire=%b chan=%b cnt=%0d want 001/1/2", fire_a, fc_a, ec_a); end
        tick();
        vectors++; if (fire_a !== 3'b000) begin miscompares++; $display("FAIL long_refire fire=%b want 000", fire_a); end
        tick();
        te_a = 2'b00; tick();
        vectors++; if (fire_a !== 3'b000 || ec_a !== 2'd2) begin miscompares++; $display("FAIL long_idle_exit fire=%b cnt=%0d want 000/2", fire_a, ec_a); end
    endtask

    task automatic test_back_to_back;
        te_a = 2'b00; tick();
        te_a = 2'b10; tick();
        repeat (2) tick();
        val_a = 2'b01; te_a = 2'b01; tick();
        vectors++; if (fire_a !== 3'b100) begin miscompares++; $display("FAIL b2b_exit fire=%b want 100", fire_a); end
        tick();
        vectors++; if (fire_a !== 3'b000) begin miscompares++; $display("FAIL b2b_idle fire=%b want 000", fire_a); end
        te_a = 2'b00; tick();
        vectors++; if (fire_a !== 3'b000 || ec_a !== 2'd2) begin miscompares++; $display("FAIL b2b_no_reentry fire=%b cnt=%0d want 000/2", fire_a, ec_a); end
        val_a = 2'b10;
    endtask

    task automatic test_saturate;
        for (int k = 0; k < 3; k++) begin
            te_a = 2'b10; tick();
            te_a = 2'b00; tick();
            vectors++; if (fire_a !== 3'b001 || ec_a !== 2'd3) begin miscompares++; $display("FAIL sat_%0d fire=%b cnt=%0d want 001/3", k, fire_a, ec_a); end
        end
    endtask

    task automatic test_enable;
        te_a = 2'b00; tick();
        te_a = 2'b10; tick();
        en_a = 1'b0;
        for (int k = 0; k < 5; k++) begin
            te_a = (k % 2 == 0) ? 2'b01 : 2'b00; tick();
            vectors++; if (fire_a !== 3'b000) begin miscompares++; $display("FAIL en_frozen_%0d fire=%b want 000", k, fire_a); end
        end
        en_a = 1'b1;
        te_a = 2'b10; tick();
        tick();
        te_a = 2'b00; tick();
        vectors++; if (fire_a !== 3'b100 || ec_a !== 2'd3) begin miscompares++; $display("FAIL en_resume fire=%b cnt=%0d want 100/3", fire_a, ec_a); end
    endtask

    task automatic test_multi;
        te_b = 8'b10_00_00_10; tick();
        te_b = 8'h00; tick();
        vectors++; if (fire_b !== 3'b001 || fc_b !== 4'b1001 || ec_b !== 8'd1) begin miscompares++; $display("FAIL multi_fire fire=%b chan=%b cnt=%0d want 001/1001/1", fire_b, fc_b, ec_b); end
        tick();
        vectors++; if (fire_b !== 3'b000 || fc_b !== 4'b0000 || ec_b !== 8'd1) begin miscompares++; $display("FAIL multi_pulse fire=%b chan=%b cnt=%0d want 000/0000/1", fire_b, fc_b, ec_b); end
        te_b = 8'b00_00_10_00; tick();
        repeat (9) tick();
        vectors++; if (fire_b !== 3'b000) begin miscompares++; $display("FAIL multi_unbounded fire=%b want 000", fire_b); end
        te_b = 8'h00; tick();
        vectors++; if (fire_b !== 3'b100 || fc_b !== 4'b0000) begin miscompares++; $display("FAIL multi_cover fire=%b chan=%b want 100/0000", fire_b, fc_b); end
    endtask

    task automatic test_value_change;
        te_b = 8'b00_10_00_00; tick();
        val_b = 8'b10_11_10_10; tick();
        vectors++; if (fire_b !== 3'b000 || fc_b !== 4'b0000) begin miscompares++; $display("FAIL vchg_ignored fire=%b chan=%b want 000/0000", fire_b, fc_b); end
        tick();
        te_b = 8'h00; tick();
        vectors++; if (fire_b !== 3'b100 || ec_b !== 8'd1) begin miscompares++; $display("FAIL vchg_cover fire=%b cnt=%0d want 100/1", fire_b, ec_b); end
        val_b = 8'b10101010;
    endtask

    task automatic test_reset_midhold;
        te_a = 2'b00; tick();
        te_a = 2'b10; tick();
        tick();
        #2 rst_n = 1'b0;
        #1;
        vectors++; if (fire_a !== 3'b000 || fc_a !== 1'b0 || ec_a !== 2'd0) begin miscompares++; $display("FAIL rst_async fire=%b chan=%b cnt=%0d want 000/0/0", fire_a, fc_a, ec_a); end
        vectors++; if (ec_b !== 8'd0) begin miscompares++; $display("FAIL rst_async_b cnt=%0d want 0", ec_b); end
        tick();
        rst_n = 1'b1;
        tick();
        tick();
        te_a = 2'b00; tick();
        vectors++; if (fire_a !== 3'b000 || ec_a !== 2'd0) begin miscompares++; $display("FAIL rst_no_entry fire=%b cnt=%0d want 000/0", fire_a, ec_a); end
        te_a = 2'b10; tick();
        te_a = 2'b00; tick();
        vectors++; if (fire_a !== 3'b001 || ec_a !== 2'd1) begin miscompares++; $display("FAIL rst_rearmed fire=%b cnt=%0d want 001/1", fire_a, ec_a); end
    endtask

    initial begin
        test_reset();
        test_success();
        test_too_short();
        test_too_long();
        test_back_to_back();
        test_saturate();
        test_enable();
        test_multi();
        test_value_change();
        test_reset_midhold();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/ovl_hold_value_mc.md
Name: ovl_hold_value_mc

Overview:
Multi-channel, parametrised successor to the single-channel hold-value checker. Each of NUM_CH independent channels watches a WIDTH-bit slice of test_expr. When a slice changes to its expected value, it must then hold that value for a bounded window of MIN..MAX cycles. The block adds per-channel reporting, a latched expected value, distinct too-short/too-long violations, a saturating error counter and a cover event. It sits alongside the other OVL checkers and is bound into designs in the same way.

Parameters:
severity_level, 1, OVL severity (0 fatal, 1 error, 2 warning, 3 info); reporting only.
NUM_CH, 4, number of independent channels (>=1).
WIDTH, 2, bits per channel slice.
MIN, 1, minimum hold cycles (0 = no lower bound).
MAX, 0, maximum hold cycles (0 = unbounded); MAX!=0 && MAX<MIN is a parameter error.
property_type, 0, 0 assert, 1 assume, 2 ignore (fire[0] and fire_chan forced 0).
coverage_level, 2, bitmask; bit1 enables fire[2].
COUNT_W, 8, width of err_count.
msg, "VIOLATION", report string.

Ports:
clock  input  1  sampling clock, rising edge
reset  input  1  asynchronous, active-low reset
enable  input  1  1 = sample and evaluate; 0 = freeze all state
test_expr  input  NUM_CH*WIDTH  channel i = bits [i*WIDTH +: WIDTH]
value  input  NUM_CH*WIDTH  expected hold value per channel
fire  output  3  [0] assertion fail, [1] X/Z on test_expr, [2] cover: successful hold
fire_chan  output  NUM_CH  per-channel fail pulse
err_count  output  COUNT_W  saturating count of violation cycles

Behaviour:
- Reset (reset==0, asynchronous):
  - all outputs 0.
  - every channel in IDLE; cnt=0; prev_valid=0.
- Sampling: only on posedge clock with enable==1. With enable==0:
  - state, cnt, prev and latched value hold.
  - fire and fire_chan are 0 on the next cycle.
- Per channel (prev = last sampled test_expr slice):
  - First enabled sample after reset only loads prev and sets prev_valid. No entry can occur on that sample.
  - IDLE -> HOLD when prev_valid && slice!=prev && slice==value_i.
    - Latch vlat_i=value_i.
    - cnt=1.
  - HOLD, slice==vlat_i: cnt++.
    - If MAX!=0 and the new cnt>MAX: too-long violation, -> IDLE, cnt=0.
  - HOLD, slice!=vlat_i:
    - If MIN!=0 and cnt<MIN: too-short violation.
    - Else: success (cover).
    - Either way -> IDLE. The sample that leaves HOLD cannot re-enter HOLD in the same cycle, even if slice equals the new value_i.
  - Changes on value_i during HOLD are ignored; the comparison always uses vlat_i.
  - cnt width: clog2(max(MIN,MAX)+2). It saturates at the all-ones value when MAX==0.
- Output timing:
  - All outputs are registered; latency is 1 cycle after the deciding sample.
  - Each event is a 1-cycle pulse.
- Output bits:
  - fire_chan[i]: violation on channel i.
  - fire[0]: OR of fire_chan.
  - fire[2]: OR of per-channel success, gated by coverage_level bit1.
  - fire[1]: any bit of test_expr is X/Z while enable==1. Simulation only; constant 0 in synthesis. A channel with X/Z on its slice does not change state that cycle.
- err_count:
  - +1 for each cycle with fire[0] set, not per channel.
  - Saturates at 2^COUNT_W-1; cleared only by reset.
- Simultaneous violations on several channels produce one fire[0] pulse and a multi-bit fire_chan.
- Reset asserted mid-HOLD: the channel is abandoned with no violation reported; outputs clear immediately.
- MIN==0 && MAX==0: violations are impossible; only cover fires.

Test Plan:
- NUM_CH=1, WIDTH=2, MIN=3, MAX=5, value=2'b10. test_expr 00 -> 10 held 4 cycles -> 01 -> fire[2] pulses 1 cycle after the 01 sample; fire[0]=0; err_count=0.
- Same config, 10 held 2 cycles then 00 -> fire[0]=1 and fire_chan[0]=1 for exactly 1 cycle; err_count=1.
- Same config, 10 held 7 cycles -> fire[0] pulses on the cycle after the 6th held sample (cnt=6>5); channel returns to IDLE; holding 10 longer does not re-fire.
- NUM_CH=4, MIN=2, MAX=0:
  - channels 0 and 3 violate on the same sample -> one fire[0] pulse, fire_chan=4'b1001, err_count +1.
  - value changes to 11 mid-hold -> ignored, no violation from that change.
- enable=0 for 5 cycles mid-hold with test_expr toggling -> no fire and cnt frozen. With MIN=3, after re-enable, 10 held for 2 more samples then 00 -> success cover (cnt=3 from 1 sample before plus 2 after).
- reset pulled low asynchronously mid-hold, between edges -> outputs 0 at once. After release, the first sample (already 10) causes no entry. COUNT_W=2 with 5 violations -> err_count stays at 3.
